// File: rtl/uart_prog_loader.sv
// UART program loader: parses SYNC/ADDR/LEN/DATA/CSUM frames, writes the
// payload to program memory, and replies with an ACK or NAK byte.
module uart_prog_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NAK_BYTE       = 8'h15,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       done,
    output logic       error
);

    localparam int unsigned TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RESP,
        S_TXWAIT_HI,
        S_TXWAIT_LO
    } state_t;

    state_t        state, state_n;
    logic [7:0]    base, base_n;
    logic [7:0]    sum, sum_n;
    logic [8:0]    remaining, remaining_n;
    logic [7:0]    index, index_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          ack_sent, ack_sent_n;

    logic [7:0]    tx_data_n;
    logic          tx_start_n;
    logic          mem_we_n;
    logic [7:0]    mem_addr_n;
    logic [7:0]    mem_wdata_n;
    logic          cpu_hold_n;
    logic          done_n;
    logic          error_n;
    logic          timed;

    // State, frame context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            base      <= 8'h00;
            sum       <= 8'h00;
            remaining <= 9'd0;
            index     <= 8'h00;
            tcnt      <= '0;
            ack_sent  <= 1'b0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'h00;
            mem_wdata <= 8'h00;
            cpu_hold  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            sum       <= sum_n;
            remaining <= remaining_n;
            index     <= index_n;
            tcnt      <= tcnt_n;
            ack_sent  <= ack_sent_n;
            tx_data   <= tx_data_n;
            tx_start  <= tx_start_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            cpu_hold  <= cpu_hold_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    // Next-state, frame bookkeeping and next output values.
    always_comb begin
        state_n     = state;
        base_n      = base;
        sum_n       = sum;
        remaining_n = remaining;
        index_n     = index;
        tcnt_n      = '0;
        ack_sent_n  = ack_sent;
        tx_data_n   = tx_data;
        tx_start_n  = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_hold_n  = cpu_hold;
        done_n      = 1'b0;
        error_n     = 1'b0;

        // Inter-byte timer only runs while a frame is being received.
        timed = (state == S_ADDR) || (state == S_LEN) ||
                (state == S_DATA) || (state == S_CSUM);
        if (timed && !rx_ready) begin
            tcnt_n = tcnt + TW'(1);
        end

        case (state)
            S_IDLE: begin
                if (rx_ready && (rx_data == SYNC_BYTE)) begin
                    state_n    = S_ADDR;
                    cpu_hold_n = 1'b1;
                end
            end
            S_ADDR: begin
                if (rx_ready) begin
                    base_n  = rx_data;
                    sum_n   = rx_data;
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_ready) begin
                    remaining_n = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                    sum_n       = sum + rx_data;
                    index_n     = 8'h00;
                    state_n     = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_ready) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = base + index;
                    mem_wdata_n = rx_data;
                    sum_n       = sum + rx_data;
                    index_n     = index + 8'd1;
                    remaining_n = remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        state_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_ready) begin
                    if (rx_data == sum) begin
                        tx_data_n  = ACK_BYTE;
                        ack_sent_n = 1'b1;
                    end else begin
                        tx_data_n  = NAK_BYTE;
                        ack_sent_n = 1'b0;
                        error_n    = 1'b1;
                    end
                    state_n = S_RESP;
                end
            end
            S_RESP: begin
                if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    state_n    = S_TXWAIT_HI;
                end
            end
            S_TXWAIT_HI: begin
                if (tx_busy) begin
                    state_n = S_TXWAIT_LO;
                end
            end
            S_TXWAIT_LO: begin
                if (!tx_busy) begin
                    state_n    = S_IDLE;
                    cpu_hold_n = 1'b0;
                    done_n     = ack_sent;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Host went quiet mid-frame: abandon it without a response byte.
        if (timed && !rx_ready && (tcnt_n == T_LIMIT)) begin
            state_n     = S_IDLE;
            cpu_hold_n  = 1'b0;
            error_n     = 1'b1;
            tcnt_n      = '0;
            mem_we_n    = 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: table-driven and random frames
// against a frame-level reference model, plus timeout and reset sequences.
module tb_uart_prog_loader;

    localparam int unsigned TO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       done;
    logic       error;

    uart_prog_loader #(
        .SYNC_BYTE      (8'hA5),
        .ACK_BYTE       (8'h06),
        .NAK_BYTE       (8'h15),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] len;
        bit         bad;
        bit         exp_ack;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q[$];
    logic [7:0] exp_addr_q[$];
    logic [7:0] exp_data_q[$];
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         start_cnt, done_cnt, err_cnt, both_cnt;
    logic [7:0] start_data;
    vec_t       vecs[6];

    initial begin
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Output monitor: collects writes and pulses.
    initial begin
        both_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we) begin
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end
                if (tx_start) begin
                    start_cnt++;
                    start_data = tx_data;
                end
                if (done) done_cnt++;
                if (error) err_cnt++;
                if (done && error) both_cnt++;
            end
        end
    end

    // Transmitter model: goes busy shortly after tx_start, then idles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                repeat (2) @(negedge clk);
                tx_busy = 1'b1;
                repeat (8) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_caps();
        wr_addr_q.delete();
        wr_data_q.delete();
        start_cnt  = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        start_data = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // Build SYNC,ADDR,LEN,data...,CSUM; mode 1 makes data equal to its index.
    task automatic build_frame(input logic [7:0] addr, input logic [7:0] lenb,
                               input bit bad, input bit mode);
        logic [7:0] s;
        logic [7:0] d;
        int         n;
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(addr);
        frame_q.push_back(lenb);
        s = addr + lenb;
        n = (lenb == 8'h00) ? 256 : int'(lenb);
        for (int i = 0; i < n; i++) begin
            d = mode ? 8'(i) : 8'($urandom);
            frame_q.push_back(d);
            s = s + d;
        end
        frame_q.push_back(bad ? s + 8'd1 : s);
    endtask

    // Reference model: expected memory writes derived from the frame bytes.
    task automatic model_writes();
        int n;
        exp_addr_q.delete();
        exp_data_q.delete();
        n = (frame_q[2] == 8'h00) ? 256 : int'(frame_q[2]);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(8'(int'(frame_q[1]) + i));
            exp_data_q.push_back(frame_q[3 + i]);
        end
    endtask

    task automatic run_frame(input bit exp_ack, input string tag);
        int n;
        int nw;
        clear_caps();
        model_writes();
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], $urandom_range(0, 3));
            if (i == 0) check({tag, " hold_after_sync"}, int'(cpu_hold), 1);
        end
        n = 0;
        while (cpu_hold && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " hold_release"}, int'(cpu_hold), 0);
        repeat (3) @(negedge clk);
        check({tag, " write_count"}, wr_addr_q.size(), exp_addr_q.size());
        nw = (wr_addr_q.size() < exp_addr_q.size()) ? wr_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < nw; i++) begin
            check({tag, " wr_addr"}, int'(wr_addr_q[i]), int'(exp_addr_q[i]));
            check({tag, " wr_data"}, int'(wr_data_q[i]), int'(exp_data_q[i]));
        end
        check({tag, " tx_start_count"}, start_cnt, 1);
        check({tag, " tx_data"}, int'(start_data), exp_ack ? 32'h06 : 32'h15);
        check({tag, " done_count"}, done_cnt, exp_ack ? 1 : 0);
        check({tag, " error_count"}, err_cnt, exp_ack ? 0 : 1);
    endtask

    initial begin
        int  n;
        bit  bad;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        clear_caps();

        vecs[0] = '{addr: 8'h20, len: 8'h01, bad: 1'b0, exp_ack: 1'b1};
        vecs[1] = '{addr: 8'hF0, len: 8'h20, bad: 1'b0, exp_ack: 1'b1};
        vecs[2] = '{addr: 8'hFE, len: 8'h05, bad: 1'b1, exp_ack: 1'b0};
        vecs[3] = '{addr: 8'h80, len: 8'h03, bad: 1'b0, exp_ack: 1'b1};
        vecs[4] = '{addr: 8'h00, len: 8'hFF, bad: 1'b0, exp_ack: 1'b1};
        vecs[5] = '{addr: 8'h7F, len: 8'h10, bad: 1'b1, exp_ack: 1'b0};

        repeat (4) @(negedge clk);
        check("reset_outputs",
              int'({tx_data, tx_start, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Noise before a frame is ignored.
        clear_caps();
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        check("noise_hold", int'(cpu_hold), 0);
        check("noise_writes", wr_addr_q.size(), 0);

        frame_q = {8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h58};
        run_frame(1'b1, "good");
        check("good_tx_data_held", int'(tx_data), 32'h06);

        frame_q = {8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h66};
        run_frame(1'b1, "wrap");

        frame_q = {8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h59};
        run_frame(1'b0, "badsum");

        build_frame(8'h00, 8'h00, 1'b0, 1'b1);
        check("len0_csum_byte", int'(frame_q[frame_q.size() - 1]), 32'h80);
        run_frame(1'b1, "len0");

        for (int v = 0; v < 6; v++) begin
            build_frame(vecs[v].addr, vecs[v].len, vecs[v].bad, 1'b0);
            run_frame(vecs[v].exp_ack, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 4; r++) begin
            bad = 1'($urandom_range(0, 1));
            build_frame(8'($urandom), 8'($urandom_range(1, 40)), bad, 1'b0);
            run_frame(!bad, $sformatf("rand%0d", r));
        end

        // Timeout after the address byte.
        clear_caps();
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        n = 0;
        while (!error && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("timeout_seen", int'(error), 1);
        check("timeout_window", int'((n >= int'(TO) - 1) && (n <= int'(TO) + 1)), 1);
        check("timeout_hold", int'(cpu_hold), 0);
        repeat (5) @(negedge clk);
        check("timeout_err_count", err_cnt, 1);
        check("timeout_no_tx", start_cnt, 0);
        check("timeout_no_done", done_cnt, 0);
        frame_q = {8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h58};
        run_frame(1'b1, "after_timeout");

        // Reset in the middle of the data phase.
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h08, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              int'({tx_data, tx_start, mem_we, mem_addr, mem_wdata, cpu_hold, done, error}), 0);
        clear_caps();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 0);
        repeat (10) @(negedge clk);
        check("midreset_no_writes", wr_addr_q.size(), 0);
        check("midreset_hold", int'(cpu_hold), 0);
        check("midreset_no_tx", start_cnt, 0);
        frame_q = {8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'h58};
        run_frame(1'b1, "after_reset");

        check("done_error_exclusive", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
